data_sram_responder: RTL and testbench

Responder for the CPU data-side SRAM-like bus: it accepts the enable, byte-write-enable, address and write-data signals driven by the core and returns read data one cycle later. It sits between the core's data port and on-chip storage. It contains a byte-writable word RAM plus a small memory-mapped peripheral page: a free-running timer, an LED register and a switch input. The functional SoC testbench instantiates it as the data memory.

---
 rtl/soc_map_pkg.sv | 34 +++
 rtl/bram_be.sv | 27 ++
 rtl/data_sram_responder.sv | 99 +++++++++
 tb/tb_data_sram_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/soc_map_pkg.sv
// rtl/soc_map_pkg.sv - physical address map and decode helper for the data-side responder
package soc_map_pkg;

   localparam logic [31:0] PERIPH_BASE = 32'h1FAF_0000;
   localparam logic [31:0] PHYS_MASK   = 32'h1FFF_FFFF;

   localparam logic [15:0] TIMER_OFF  = 16'hE000;
   localparam logic [15:0] LED_OFF    = 16'hF000;
   localparam logic [15:0] SWITCH_OFF = 16'hF020;

   typedef enum logic [2:0] {
      SEL_RAM,
      SEL_TIMER,
      SEL_LED,
      SEL_SW,
      SEL_NONE
   } selT;

   // Byte offset inside the page is compared word-aligned, so addr[1:0] never matters.
   function automatic selT decodeSel(input logic [31:0] paddr, input logic [15:0] pageHi);
      selT sel;
      sel = SEL_RAM;
      if (paddr[31:16] == pageHi) begin
         case ({paddr[15:2], 2'b00})
            TIMER_OFF:  sel = SEL_TIMER;
            LED_OFF:    sel = SEL_LED;
            SWITCH_OFF: sel = SEL_SW;
            default:    sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/bram_be.sv
// rtl/bram_be.sv - single-port byte-writable word RAM, read-first, registered read
module bram_be #(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              en,
   input  logic [3:0]        wen,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**ADDR_W];

   // Read-first: rdata takes the old word even when lanes are written in the same cycle.
   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data-side SRAM bus responder: word RAM plus timer/LED/switch page
module data_sram_responder #(
   parameter int unsigned ADDR_W      = 12,
   parameter logic [31:0] PERIPH_BASE = soc_map_pkg::PERIPH_BASE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   input  logic [7:0]  sw
);

   import soc_map_pkg::*;

   logic [31:0] paddr;
   selT         sel;
   logic        isWrite;
   logic [31:0] byteMask;
   logic        ramEn;
   logic [31:0] ramRdata;

   logic [31:0] timer;
   logic [15:0] ledReg;
   logic [31:0] periphRd;

   // Selection and peripheral data are captured at the request edge so they align with ramRdata.
   selT         selQ;
   logic [31:0] periphQ;

   assign paddr   = data_sram_addr & PHYS_MASK;
   assign sel     = decodeSel(paddr, PERIPH_BASE[31:16]);
   assign isWrite = (data_sram_wen != 4'b0000);
   assign ramEn   = data_sram_en && !rst && (sel == SEL_RAM);

   always_comb begin
      byteMask = 32'h0;
      for (int i = 0; i < 4; i++) begin
         byteMask[8*i +: 8] = {8{data_sram_wen[i]}};
      end
   end

   always_comb begin
      periphRd = 32'h0;
      case (sel)
         SEL_TIMER: periphRd = timer;
         SEL_LED:   periphRd = {16'h0, ledReg};
         SEL_SW:    periphRd = {24'h0, sw};
         default:   periphRd = 32'h0;
      endcase
   end

   // A timer write replaces the increment for that cycle only.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer <= 32'h0;
      end else if (data_sram_en && isWrite && sel == SEL_TIMER) begin
         timer <= (timer & ~byteMask) | (data_sram_wdata & byteMask);
      end else begin
         timer <= timer + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ledReg <= 16'h0;
      end else if (data_sram_en && isWrite && sel == SEL_LED) begin
         ledReg <= (ledReg & ~byteMask[15:0]) | (data_sram_wdata[15:0] & byteMask[15:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         selQ    <= SEL_NONE;
         periphQ <= 32'h0;
      end else if (data_sram_en) begin
         selQ    <= sel;
         periphQ <= periphRd;
      end
   end

   bram_be #(
      .ADDR_W (ADDR_W)
   ) uRam (
      .clk   (clk),
      .en    (ramEn),
      .wen   (data_sram_wen),
      .addr  (paddr[ADDR_W+1:2]),
      .wdata (data_sram_wdata),
      .rdata (ramRdata)
   );

   assign data_sram_rdata = (selQ == SEL_RAM) ? ramRdata : periphQ;
   assign led             = ledReg;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - scoreboard bench for data_sram_responder
module tb_data_sram_responder;

   localparam int          ADDR_W = 12;
   localparam logic [31:0] PBASE  = 32'h1FAF_0000;
   localparam logic [31:0] MASK   = 32'h1FFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  wen = 4'h0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic [15:0] led;
   logic [7:0]  sw = 8'h00;

   always #5 clk = ~clk;

   data_sram_responder #(
      .ADDR_W      (ADDR_W),
      .PERIPH_BASE (PBASE)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (en),
      .data_sram_wen   (wen),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata),
      .led             (led),
      .sw              (sw)
   );

   typedef struct {
      logic [31:0] rd;
      logic [15:0] ld;
      string       tag;
   } expT;

   expT         q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;

   logic [31:0] ramM [int];
   logic [15:0] ledM = 16'h0;
   logic [31:0] tBase = 32'h0;
   int          tCycle = 0;
   int          ramIdx[16];

   always @(posedge clk) cyc++;

   function automatic logic [31:0] merge(input logic [31:0] oldV, input logic [31:0] newV,
                                         input logic [3:0] w);
      logic [31:0] r;
      r = oldV;
      for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = newV[8*i +: 8];
      return r;
   endfunction

   // Reference behaviour for one bus cycle, evaluated before the edge it lands on.
   task automatic drive(input logic r, input logic e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
      int          edgeN;
      logic [31:0] p;
      logic [31:0] tNow;
      logic [31:0] rd;
      logic [31:0] tmp;
      logic [15:0] off;
      int          idx;
      expT         x;
      @(negedge clk);
      rst = r; en = e; wen = w; addr = a; wdata = d;
      edgeN = cyc + 1;
      p     = a & MASK;
      tNow  = tBase + 32'(edgeN - 1 - tCycle);
      rd    = 32'h0;
      if (r) begin
         tBase = 32'h0; tCycle = edgeN; ledM = 16'h0;
         x.rd = 32'h0; x.ld = 16'h0; x.tag = tag;
         q.push_back(x);
      end else if (e) begin
         if (p[31:16] == PBASE[31:16]) begin
            off = {p[15:2], 2'b00};
            case (off)
               16'hE000: begin
                  rd = tNow;
                  if (w != 4'h0) begin tBase = merge(tNow, d, w); tCycle = edgeN; end
               end
               16'hF000: begin
                  rd = {16'h0, ledM};
                  tmp = merge({16'h0, ledM}, d, w);
                  ledM = tmp[15:0];
               end
               16'hF020: rd = {24'h0, sw};
               default:  rd = 32'h0;
            endcase
         end else begin
            idx = int'(p[ADDR_W+1:2]);
            rd  = ramM.exists(idx) ? ramM[idx] : 32'h0;
            if (w != 4'h0) ramM[idx] = merge(rd, d, w);
         end
         x.rd = rd; x.ld = ledM; x.tag = tag;
         q.push_back(x);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "idle");
   endtask

   initial begin : monitor
      logic sampled;
      expT  x;
      forever begin
         @(posedge clk);
         sampled = (rst === 1'b1) || (en === 1'b1);
         #1;
         if (sampled) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL underrun: DUT produced a response with no expectation queued");
            end else begin
               x = q.pop_front();
               if (rdata !== x.rd) begin
                  miscompares++;
                  $display("FAIL %s rdata: got %h expected %h", x.tag, rdata, x.rd);
               end
               if (led !== x.ld) begin
                  miscompares++;
                  $display("FAIL %s led: got %h expected %h", x.tag, led, x.ld);
               end
            end
         end
      end
   end

   initial begin : stimulus
      logic [31:0] a;
      logic [31:0] p;
      logic [31:0] d;
      logic [3:0]  w;
      int          kind;
      int          k;

      drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, "reset");
      for (int i = 0; i < 16; i++) begin
         ramIdx[i] = (i * 37 + 5) % (2**ADDR_W);
         drive(1'b0, 1'b1, 4'hF, 32'(ramIdx[i]) << 2, $urandom, "init");
      end

      drive(1'b0, 1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, "alias_wr");
      drive(1'b0, 1'b1, 4'h0, 32'hA000_0010, 32'h0, "alias_rd");

      drive(1'b0, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, "lane_pre");
      drive(1'b0, 1'b1, 4'b0101, 32'h0000_0020, 32'hAABB_CCDD, "lane_wr");
      drive(1'b0, 1'b1, 4'h0, 32'h0000_0020, 32'h0, "lane_rd");

      drive(1'b0, 1'b1, 4'hF, 32'h0000_0030, 32'h1, "rf_pre");
      drive(1'b0, 1'b1, 4'hF, 32'h0000_0030, 32'h2, "rf_wr");
      drive(1'b0, 1'b1, 4'h0, 32'h0000_0030, 32'h0, "rf_rd");

      drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, "reset2");
      idle(10);
      drive(1'b0, 1'b1, 4'h0, 32'hBFAF_E000, 32'h0, "timer10");
      drive(1'b0, 1'b1, 4'hF, 32'h9FAF_E000, 32'hFFFF_FFFE, "timer_wr");
      idle(2);
      drive(1'b0, 1'b1, 4'h0, 32'h9FAF_E000, 32'h0, "timer_wrap");

      drive(1'b0, 1'b1, 4'hF, 32'h9FAF_F000, 32'h1234_ABCD, "led_wr");
      drive(1'b0, 1'b1, 4'h0, 32'h9FAF_F000, 32'h0, "led_rd");
      drive(1'b0, 1'b1, 4'b0010, 32'h9FAF_F000, 32'h0000_5500, "led_lane");
      sw = 8'h5A;
      drive(1'b0, 1'b1, 4'hF, 32'h9FAF_F020, 32'hFFFF_FFFF, "sw_wr");
      drive(1'b0, 1'b1, 4'h0, 32'h9FAF_F020, 32'h0, "sw_rd");
      drive(1'b0, 1'b1, 4'hF, 32'h9FAF_0100, 32'h7777_7777, "unmap_wr");
      drive(1'b0, 1'b1, 4'h0, 32'h9FAF_0100, 32'h0, "unmap_rd");

      drive(1'b0, 1'b1, 4'hF, 32'h0000_0040, 32'hCAFE_0001, "keep_wr");
      drive(1'b0, 1'b1, 4'h0, 32'h9FAF_F000, 32'h0, "pre_rst_rd");
      drive(1'b1, 1'b1, 4'h0, 32'h0000_0040, 32'h0, "rst_mid");
      drive(1'b0, 1'b1, 4'h0, 32'h9FAF_E000, 32'h0, "timer_after_rst");
      drive(1'b0, 1'b1, 4'h0, 32'h8000_0040, 32'h0, "keep_rd");

      for (int n = 0; n < 600; n++) begin
         kind = int'($urandom_range(0, 60));
         d    = $urandom;
         w    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         if (kind == 0) begin
            drive(1'b1, 1'($urandom), w, $urandom, d, "rnd_rst");
         end else if (kind < 30) begin
            k = int'($urandom_range(0, 15));
            a = $urandom;
            a[ADDR_W+1:2] = ramIdx[k][ADDR_W-1:0];
            p = a & MASK;
            if (p[31:16] == PBASE[31:16]) a[20] = ~a[20];
            drive(1'b0, 1'b1, w, a, d, "rnd_ram");
         end else if (kind < 48) begin
            a = {3'($urandom), PBASE[28:16], 16'h0};
            case ($urandom_range(0, 3))
               0: a[15:0] = 16'hE000;
               1: a[15:0] = 16'hF000;
               2: a[15:0] = 16'hF020;
               default: a[15:0] = 16'($urandom);
            endcase
            a[1:0] = 2'($urandom);
            drive(1'b0, 1'b1, w, a, d, "rnd_periph");
         end else begin
            if (kind == 60) sw = 8'($urandom);
            idle(1);
         end
      end
      idle(3);

      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
